// File: rtl/reload_timer_ctrl.sv
// Reload timer sequencer: owns an up-counter with parallel load and auto-reload,
// runs the arm/run/hold/done state machine, and emits wrap ticks and completion.
module reload_timer_ctrl #(
    parameter int WIDTH  = 8,
    parameter int REPS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic              mode_periodic,
    input  logic [WIDTH-1:0]  reload_val,
    input  logic [REPS_W-1:0] reps,
    output logic [WIDTH-1:0]  cnt,
    output logic              load_en,
    output logic              cnt_en,
    output logic              tick,
    output logic              done,
    output logic              busy,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            cur_state, nxt_state;
    logic [WIDTH-1:0]  shadow_reload;
    logic [REPS_W-1:0] shadow_reps;
    logic              shadow_periodic;
    logic [REPS_W-1:0] wrap_cnt, wrap_cnt_inc;
    logic              accept, wrap, complete;

    assign state   = cur_state;
    assign busy    = (cur_state != IDLE);
    assign load_en = (cur_state == ARM);
    assign cnt_en  = (cur_state == RUN) & ~pause & ~abort;
    assign accept  = (cur_state == IDLE) & start & ~abort;
    assign wrap    = cnt_en & (cnt == '1);

    assign wrap_cnt_inc = (wrap_cnt == '1) ? wrap_cnt : wrap_cnt + REPS_W'(1);
    // Compare against the post-increment count so done coincides with the final tick.
    assign complete = wrap & (~shadow_periodic |
                              ((shadow_reps != '0) & (wrap_cnt_inc == shadow_reps)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (abort) begin
            nxt_state = IDLE;
        end else begin
            unique case (cur_state)
                IDLE:    if (start) nxt_state = ARM;
                ARM:     nxt_state = RUN;
                RUN: begin
                    if (pause) begin
                        nxt_state = HOLD;
                    end else if (complete) begin
                        nxt_state = DONE;
                    end
                end
                HOLD:    if (!pause) nxt_state = RUN;
                DONE:    nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= '0;
            tick            <= 1'b0;
            done            <= 1'b0;
            wrap_cnt        <= '0;
            shadow_reload   <= '0;
            shadow_reps     <= '0;
            shadow_periodic <= 1'b0;
        end else begin
            tick <= wrap;
            done <= complete;
            if (accept) begin
                shadow_reload   <= reload_val;
                shadow_reps     <= reps;
                shadow_periodic <= mode_periodic;
                wrap_cnt        <= '0;
            end
            if (load_en & ~abort) begin
                cnt <= shadow_reload;
            end else if (wrap) begin
                cnt      <= shadow_reload;
                wrap_cnt <= wrap_cnt_inc;
            end else if (cnt_en) begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule
